mult_unit: RTL and testbench



---
 rtl/mult_unit.sv | 79 +++++++
 tb/tb_mult_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add multiplier with HI/LO register file
module mult_unit #(
    parameter int STEP_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mult_start,
    input  logic        mult_signed,
    input  logic [31:0] mult_opr1,
    input  logic [31:0] mult_opr2,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int N = 32 / STEP_BITS;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          cnt;
    logic [31:0]            mag1, mag2;
    logic [63:0]            acc, acc_next, res;
    logic                   neg, commit, cancel;
    logic [31+STEP_BITS:0]  pp, sum;

    // Next state and one shift-add step: the low product bits retire into acc[31:0] from the top.
    always_comb begin
        pp = (32 + STEP_BITS)'(mag1) * (32 + STEP_BITS)'(mag2[STEP_BITS-1:0]);
        sum = (32 + STEP_BITS)'(acc[63:32]) + pp;
        acc_next = {sum, acc[31:STEP_BITS]};
        res = neg ? -acc_next : acc_next;
        commit = state == RUN && cnt == CW'(1) && !mult_start;
        cancel = state == RUN && (hi_we || lo_we) && !mult_start && !commit;
        state_next = mult_start ? RUN : (commit || cancel) ? IDLE : state;
    end

    // State, datapath and HI/LO registers; a commit beats a same-cycle MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            mag1 <= '0;
            mag2 <= '0;
            acc <= '0;
            neg <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            state <= state_next;
            busy <= state_next == RUN;
            done <= commit;
            if (mult_start) begin
                mag1 <= (mult_signed && mult_opr1[31]) ? -mult_opr1 : mult_opr1;
                mag2 <= (mult_signed && mult_opr2[31]) ? -mult_opr2 : mult_opr2;
                neg <= mult_signed & (mult_opr1[31] ^ mult_opr2[31]);
                acc <= '0;
                cnt <= CW'(N);
            end else if (state == RUN) begin
                acc <= acc_next;
                mag2 <= mag2 >> STEP_BITS;
                cnt <= cnt - CW'(1);
            end
            if (commit) begin
                hi <= res[63:32];
                lo <= res[31:0];
            end else begin
                if (hi_we) hi <= wr_data;
                if (lo_we) lo <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed and randomized checks of mult_unit against an arithmetic product model
module tb_mult_unit;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mult_start = 1'b0;
    logic        mult_signed = 1'b0;
    logic [31:0] mult_opr1 = '0;
    logic [31:0] mult_opr2 = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          tests = 0;
    int          fails = 0;

    mult_unit #(.STEP_BITS(2)) dut (
        .clk(clk), .rst(rst), .mult_start(mult_start), .mult_signed(mult_signed),
        .mult_opr1(mult_opr1), .mult_opr2(mult_opr2), .hi_we(hi_we), .lo_we(lo_we),
        .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return s ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        mult_start = 1'b1;
        mult_signed = s;
        mult_opr1 = a;
        mult_opr2 = b;
        tick();
        mult_start = 1'b0;
        mult_signed = $urandom_range(0, 1);
        mult_opr1 = $urandom;
        mult_opr2 = $urandom;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp, input logic we_at_commit);
        int bad = 0;
        for (int i = 1; i < N; i++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        chk({tag, "_busy_window"}, 64'(bad), 64'd0);
        if (we_at_commit) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wr_data = 32'hDEADBEEF;
        end
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk({tag, "_hilo"}, {hi, lo}, exp);
        chk({tag, "_done"}, {62'b0, busy, done}, 64'b01);
        tick();
        chk({tag, "_done_clear"}, 64'(done), 64'd0);
    endtask

    initial begin
        int bad;
        logic s;
        logic [31:0] a, b;
        tick();
        tick();
        rst = 1'b0;
        chk("reset", {28'b0, busy, done, 2'b0, hi, lo} >> 0, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);

        start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        finish_op("umax", 64'hFFFFFFFE_00000001, 1'b0);
        start_op(1'b1, 32'hFFFFFFFF, 32'h7);
        finish_op("smix", 64'hFFFFFFFF_FFFFFFF9, 1'b0);
        start_op(1'b0, 32'hFFFFFFFF, 32'h7);
        finish_op("umix", 64'h00000006_FFFFFFF9, 1'b0);
        start_op(1'b1, 32'h80000000, 32'h80000000);
        finish_op("minmin", 64'h40000000_00000000, 1'b0);
        start_op(1'b1, 32'h80000000, 32'h1);
        finish_op("minone", 64'hFFFFFFFF_80000000, 1'b0);

        start_op(1'b0, 32'd3, 32'd5);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done !== 1'b0) bad++;
        end
        chk("restart_first_no_done", 64'(bad), 64'd0);
        start_op(1'b0, 32'h10000, 32'h10000);
        finish_op("restart", 64'h00000001_00000000, 1'b0);

        hi_we = 1'b1;
        wr_data = 32'hAAAA0000;
        tick();
        hi_we = 1'b0;
        chk("mthi_idle", {hi, lo}, 64'hAAAA0000_00000000);
        start_op(1'b0, 32'd2, 32'd3);
        for (int i = 0; i < 3; i++) tick();
        lo_we = 1'b1;
        wr_data = 32'h1234;
        tick();
        lo_we = 1'b0;
        chk("mt_cancel_flags", {62'b0, busy, done}, 64'd0);
        chk("mt_cancel_hilo", {hi, lo}, 64'hAAAA0000_00001234);
        bad = 0;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            if (done !== 1'b0 || {hi, lo} !== 64'hAAAA0000_00001234) bad++;
        end
        chk("mt_cancel_no_commit", 64'(bad), 64'd0);

        lo_we = 1'b1;
        wr_data = 32'h5555;
        start_op(1'b0, 32'd2, 32'd3);
        lo_we = 1'b0;
        chk("mt_with_start", {hi, lo}, 64'hAAAA0000_00005555);
        finish_op("mt_with_start", 64'd6, 1'b0);

        start_op(1'b1, 32'hFFFFFFFD, 32'd11);
        finish_op("we_at_commit", ref_prod(1'b1, 32'hFFFFFFFD, 32'd11), 1'b1);

        start_op(1'b0, 32'd7, 32'd9);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", {30'b0, busy, done, hi, lo} >> 0, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        bad = 0;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== 64'd0) bad++;
        end
        chk("rst_no_commit", 64'(bad), 64'd0);

        for (int k = 0; k < 20; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (k % 5 == 0) a = 32'h80000000;
            start_op(s, a, b);
            finish_op("random", ref_prod(s, a, b), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
